// File: rtl/timer_multi.sv
// Multi-channel down-counting timer: CH channels share one prescaler, each with
// its own period, one-shot/auto-reload mode, expiry pulse and status flags.
package timer_multi_pkg;
    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_DONE = 2'd2
    } ch_state_e;
endpackage

module timer_multi
    import timer_multi_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CH       = 2,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CH-1:0]         load,
    input  logic [CH-1:0]         stop,
    input  logic [CH-1:0]         mode,
    input  logic [CH*WIDTH-1:0]   period,
    output logic [CH-1:0]         tick,
    output logic [CH-1:0]         running,
    output logic [CH-1:0]         done,
    output logic [CH*WIDTH-1:0]   count
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic          ce;

    // With PRESCALE=1 pre_q is pinned at 0 == PRE_LAST, so ce follows en.
    assign ce = en && (pre_q == PRE_LAST);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        ch_state_e        state_q;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] reload_q;
        logic             mode_q;
        logic             tick_q;
        logic [WIDTH-1:0] period_i;
        logic             load_ok;

        assign period_i = period[i*WIDTH +: WIDTH];
        // A zero-period load is treated as if no load strobe were present.
        assign load_ok  = load[i] && (period_i != '0);

        // NOTE: every channel register, including reload and mode latches, is
        // reset so the block comes up in a fully defined state.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q  <= CH_IDLE;
                cnt_q    <= '0;
                reload_q <= '0;
                mode_q   <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (load_ok) begin
                    state_q  <= CH_RUN;
                    cnt_q    <= period_i;
                    reload_q <= period_i;
                    mode_q   <= mode[i];
                end else if (stop[i]) begin
                    if (state_q == CH_RUN) begin
                        state_q <= CH_IDLE;
                    end
                end else if (state_q == CH_RUN && ce) begin
                    if (cnt_q == WIDTH'(1)) begin
                        tick_q <= 1'b1;
                        if (mode_q) begin
                            cnt_q <= reload_q;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= CH_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - WIDTH'(1);
                    end
                end
            end
        end

        assign tick[i]                   = tick_q;
        assign running[i]                = (state_q == CH_RUN);
        assign done[i]                   = (state_q == CH_DONE);
        assign count[i*WIDTH +: WIDTH]   = cnt_q;
    end

endmodule
